// File: rtl/zapper_pkg.sv
// Shared definitions for the zapper light-gun shot sequencer: FSM state
// encoding, command/status bit positions, default register address and
// debounce length, plus the status-word packing helper.
package zapper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_BLANK   = 3'd2,
        ST_TARGET  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Command word bit positions
    localparam int CMD_ARM    = 0;
    localparam int CMD_CLEAR  = 1;
    localparam int CMD_SWTRIG = 2;

    // Status word bit positions
    localparam int STAT_DONE    = 0;
    localparam int STAT_HIT     = 1;
    localparam int STAT_FAULT   = 2;
    localparam int STAT_ARM     = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam logic [15:0] DEFAULT_CMD_ADDR   = 16'hBFFC;
    localparam logic [15:0] DEFAULT_DEB_CYCLES = 16'd50000;

    // Low byte of the status word; upper bits are always zero.
    function automatic logic [7:0] pack_status(input logic [3:0] cnt,
                                               input logic       arm,
                                               input logic       fault,
                                               input logic       hit,
                                               input logic       done);
        logic [7:0] s;
        s                       = '0;
        s[STAT_DONE]            = done;
        s[STAT_HIT]             = hit;
        s[STAT_FAULT]           = fault;
        s[STAT_ARM]             = arm;
        s[STAT_CNT_LSB +: 4]    = cnt;
        return s;
    endfunction

endpackage

// File: rtl/zapper_sync.sv
// Trigger conditioning: 2-FF synchronizer followed by a rising-edge pulse.
// With ZAPPER_DEBOUNCE_EN defined, the pulse is only produced once the
// synchronized level has been stable high for DEB_CYCLES clocks, and the
// filtered level must then be stable low for DEB_CYCLES before re-arming.
module zapper_sync
    import zapper_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;

    // Two-stage synchronizer for the asynchronous input
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

`ifdef ZAPPER_DEBOUNCE_EN
    logic        r_deb;
    logic [15:0] r_debCnt;
    logic        w_debDone;

    assign w_debDone = (r_debCnt == (DEB_CYCLES - 16'd1));

    // Filtered level follows the synced level only after a full stable run
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_deb    <= 1'b0;
            r_debCnt <= '0;
        end else if (r_sync == r_deb) begin
            r_debCnt <= '0;
        end else if (w_debDone) begin
            r_deb    <= r_sync;
            r_debCnt <= '0;
        end else begin
            r_debCnt <= r_debCnt + 16'd1;
        end
    end

    assign o_rise = w_debDone & r_sync & ~r_deb;
`else
    logic r_prev;

    // Previous synced level, used for raw rising-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
`endif

endmodule

// File: rtl/zapper_shot_ctrl.sv
// Zapper shot sequencer. The CPU arms the block through the command
// register (or fires it directly with SWTRIG); a trigger edge then blanks
// one video frame and shows the target for the next, sampling the
// photodiode in each. Results are latched in a registered status word.
// Optional trigger debounce is enabled by defining ZAPPER_DEBOUNCE_EN.
module zapper_shot_ctrl
    import zapper_pkg::*;
#(
    parameter int                       WIDTH         = 16,
    parameter int                       RAM_ADDR_BITS = 16,
    parameter logic [RAM_ADDR_BITS-1:0] CMD_ADDR      = RAM_ADDR_BITS'(DEFAULT_CMD_ADDR),
    parameter logic [15:0]              DEB_CYCLES    = DEFAULT_DEB_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [RAM_ADDR_BITS-1:0] adr,
    input  logic [WIDTH-1:0]         writedata,
    input  logic                     trigger_in,
    input  logic                     detect_in,
    input  logic                     vsync_pulse,
    output logic                     blank_screen,
    output logic                     show_target,
    output logic                     busy,
    output logic [WIDTH-1:0]         status
);

    state_t     r_state;
    logic       r_arm;
    logic       r_done;
    logic       r_hit;
    logic       r_fault;
    logic [3:0] r_shotCnt;
    logic       r_blank;
    logic       r_show;
    logic       r_busy;
    logic [WIDTH-1:0] r_status;
    logic       r_detMeta;
    logic       r_detSync;

    logic w_trigRise;
    logic w_cmdWr;
    logic w_start;

    zapper_sync #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_trigSync (
        .clk     (clk),
        .reset   (reset),
        .i_async (trigger_in),
        .o_rise  (w_trigRise)
    );

    assign w_cmdWr = memwrite && (adr == CMD_ADDR);
    assign w_start = (w_trigRise && r_arm) || (w_cmdWr && writedata[CMD_SWTRIG]);

    // Photodiode synchronizer; only the level is needed, no edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_detMeta <= 1'b0;
            r_detSync <= 1'b0;
        end else begin
            r_detMeta <= detect_in;
            r_detSync <= r_detMeta;
        end
    end

    // Command decode and shot sequence; state transitions override commands
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_arm     <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= 1'b0;
            r_fault   <= 1'b0;
            r_shotCnt <= '0;
            r_blank   <= 1'b0;
            r_show    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_cmdWr && writedata[CMD_ARM]) begin
                r_arm <= 1'b1;
            end
            if (w_cmdWr && writedata[CMD_CLEAR]) begin
                r_done <= 1'b0;
                if (r_state == ST_IDLE) begin
                    r_hit   <= 1'b0;
                    r_fault <= 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_WAIT_VS;
                        r_hit   <= 1'b0;
                        r_fault <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_VS: begin
                    if (vsync_pulse) begin
                        r_state <= ST_BLANK;
                        r_blank <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (r_detSync) begin
                        r_fault <= 1'b1;
                    end
                    if (vsync_pulse) begin
                        r_state <= ST_TARGET;
                        r_blank <= 1'b0;
                        r_show  <= 1'b1;
                    end
                end
                ST_TARGET: begin
                    if (r_detSync) begin
                        r_hit <= 1'b1;
                    end
                    if (vsync_pulse) begin
                        r_state   <= ST_DONE;
                        r_show    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_arm     <= 1'b0;
                        r_shotCnt <= r_shotCnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_blank <= 1'b0;
                    r_show  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Status word trails the flag registers by one clock
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_status <= '0;
        end else begin
            r_status <= WIDTH'(pack_status(r_shotCnt, r_arm, r_fault, r_hit, r_done));
        end
    end

    assign blank_screen = r_blank;
    assign show_target  = r_show;
    assign busy         = r_busy;
    assign status       = r_status;

endmodule
